// File: rtl/shift_pipe_unit.sv
// Two-stage pipelined RV32 shift unit (SLL/SRL/SRA) built around a left-only barrel shifter.
// Right shifts bit-reverse the operand in S1, shift left, then reverse back and sign-fill.
module shift_pipe_unit #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [4:0]       req_shamt,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // S1 state
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [4:0]       s1_shamt_q, s1_shamt_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // S2 state
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  logic s2_free;
  logic s1_adv;
  logic req_acc;

  assign s2_free   = !s2_valid_q || rsp_ready;
  assign s1_adv    = s1_valid_q && s2_free;
  assign req_ready = (!s1_valid_q || s1_adv) && !flush;
  assign req_acc   = req_valid && req_ready;

  // Zero-filling left barrel shifter, one mux level per shamt bit.
  logic [31:0] stg [6];
  assign stg[0] = s1_a_q;

  for (genvar k = 0; k < 5; k++) begin : g_shift
    localparam int Sh = 1 << k;
    assign stg[k+1] = s1_shamt_q[k] ? {stg[k][31-Sh:0], {Sh{1'b0}}} : stg[k];
  end

  logic [31:0] shl;
  logic [31:0] shl_rev;
  logic [31:0] fill_mask;

  assign shl       = stg[5];
  assign shl_rev   = bit_rev(shl);
  assign fill_mask = bit_rev(~(32'hFFFF_FFFF << s1_shamt_q));

  // S1 next state: pre-reverse operands of right shifts.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_shamt_d = s1_shamt_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (req_ready) begin
      s1_valid_d = req_valid;
      if (req_valid) begin
        s1_a_d     = (req_op == OpSrl || req_op == OpSra) ? bit_rev(req_a) : req_a;
        s1_shamt_d = req_shamt;
        s1_op_d    = req_op;
        s1_tag_d   = req_tag;
      end
    end
  end

  // S2 next state. The original sign bit sits at s1_a_q[0] after reversal.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_err_d   = s2_err_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_tag_d = s1_tag_q;
        s2_err_d = 1'b0;
        unique case (s1_op_q)
          OpSll:   s2_data_d = shl;
          OpSrl:   s2_data_d = shl_rev;
          OpSra:   s2_data_d = shl_rev | (s1_a_q[0] ? fill_mask : 32'h0);
          default: begin
            s2_data_d = 32'h0;
            s2_err_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_shamt_q <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_shamt_q <= s1_shamt_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_data  = s2_data_q;
  assign rsp_tag   = s2_tag_q;
  assign rsp_err   = s2_err_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Scoreboard bench for shift_pipe_unit: expected results queued at acceptance, checked on transfer.
module tb_shift_pipe_unit;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [4:0]       req_shamt;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  shift_pipe_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_shamt (req_shamt),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic last_acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
    e.err = 1'b0;
    case (op)
      2'b00:   e.data = a << sh;
      2'b01:   e.data = a >> sh;
      2'b10:   e.data = $unsigned($signed(a) >>> sh);
      default: begin
        e.data = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    exp_t e;
    #1;
    last_acc = req_valid && req_ready;
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, e.tag});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
    if (last_acc) sb_q.push_back(model(req_op, req_a, req_shamt, req_tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_shamt = sh;
    req_tag   = tag;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) step();
    chk("drain_left", sb_q.size(), 32'h0);
  endtask

  task automatic single_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                           input logic [TAG_W-1:0] tag);
    rsp_ready = 1'b1;
    drive(1'b1, op, a, sh, tag);
    step();
    chk("acc", {31'b0, last_acc}, 32'h1);
    req_valid = 1'b0;
    chk("lat_s1_valid", {31'b0, rsp_valid}, 32'h0);
    step();
    chk("lat_s2_valid", {31'b0, rsp_valid}, 32'h1);
    step();
    chk("sb_empty", sb_q.size(), 32'h0);
  endtask

  // Fills both stages under backpressure: first op in S2, second in S1.
  task automatic fill_two(input logic [TAG_W-1:0] t0);
    rsp_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0003, 5'd1, t0);
    step();
    drive(1'b1, 2'b01, 32'hF000_0000, 5'd8, t0 + 1'b1);
    step();
    chk("fill_busy", {31'b0, busy}, 32'h1);
  endtask

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_tag", {28'b0, rsp_tag}, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // Individual ops and boundaries
    single_op(2'b00, 32'h0000_0001, 5'd31, 4'd1);
    single_op(2'b01, 32'h8000_0000, 5'd4, 4'd2);
    single_op(2'b10, 32'h8000_0000, 5'd4, 4'd3);
    single_op(2'b10, 32'h7FFF_FFFF, 5'd31, 4'd4);
    single_op(2'b10, 32'h8000_0001, 5'd0, 4'd6);
    single_op(2'b11, 32'hFFFF_FFFF, 5'd7, 4'd5);
    single_op(2'b01, 32'hDEAD_BEEF, 5'd0, 4'd7);
    single_op(2'b10, 32'hC000_1234, 5'd31, 4'd8);

    // Back-to-back
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 3), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      #1 chk("b2b_req_ready", {31'b0, req_ready}, 32'h1);
      step();
    end
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h8765_4321, 5'd3, 4'd1);
    step();
    drive(1'b1, 2'b00, 32'h1234_5678, 5'd12, 4'd2);
    step();
    drive(1'b1, 2'b01, 32'hFFFF_0000, 5'd16, 4'd3);
    #1 chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
    held = model(2'b10, 32'h8765_4321, 5'd3, 4'd1).data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_hold", rsp_data, held);
      chk("bp_tag", {28'b0, rsp_tag}, 32'h1);
    end
    rsp_ready = 1'b1;
    last_acc  = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) step();
    chk("bp_tag3_acc", {31'b0, last_acc}, 32'h1);
    drain();

    // Flush
    fill_two(4'd9);
    drive(1'b1, 2'b00, 32'h1, 5'd1, 4'd11);
    flush = 1'b1;
    #1 chk("flush_req_ready", {31'b0, req_ready}, 32'h0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    rsp_ready = 1'b1;
    repeat (3) step();
    single_op(2'b01, 32'hA5A5_A5A5, 5'd5, 4'd12);

    // Async reset mid-cycle
    fill_two(4'd13);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("arst_rsp_data", rsp_data, 32'h0);
    chk("arst_rsp_tag", {28'b0, rsp_tag}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    sb_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_req_ready", {31'b0, req_ready}, 32'h1);
    rsp_ready = 1'b1;
    repeat (4) step();
    single_op(2'b00, 32'h0000_00FF, 5'd8, 4'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_pipe_unit.md
Name: shift_pipe_unit

Overview:
- Pipelined shift execution unit for the RV32 datapath; issues SLL/SRL/SRA requests into the zero-filling 32-bit left barrel shifter and consumes its result.
- Right shifts reuse the left-only shifter: bit-reverse the operand, shift left, bit-reverse back, then apply the sign fill.
- Two register stages with valid/ready handshakes at both ends, full backpressure, flush, and in-order tagged responses.

Parameters:
- TAG_W, 4, width of the opaque request tag returned with each result.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- req_valid  input  1  request present.
- req_ready  output  1  unit accepts the request this cycle.
- req_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
- req_a  input  32  operand.
- req_shamt  input  5  shift amount, 0-31.
- req_tag  input  TAG_W  returned unchanged on rsp_tag.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  shifted result.
- rsp_tag  output  TAG_W  tag of this result.
- rsp_err  output  1  request used the illegal op; rsp_data = 0.
- busy  output  1  s1_valid OR s2_valid.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = s2_valid = 0. rsp_valid, rsp_data, rsp_tag, rsp_err and busy = 0. req_ready = 1 once rst_n is high. Reset mid-operation drops all in-flight ops; no response is ever produced for them.
- Stage S1 register holds: pre-processed operand (req_a bit-reversed when op is SRL/SRA, else unchanged), shamt, op, tag.
- Between S1 and S2, combinational logic:
  - left shift by shamt with zero fill;
  - bit-reverse the shifted value for SRL/SRA;
  - for SRA with req_a[31] = 1, OR in a fill mask equal to the bit-reverse of (0xFFFFFFFF << shamt) inverted, so the top shamt bits are 1.
- Stage S2 register holds the final rsp_data, rsp_tag and rsp_err. The outputs are driven directly from S2.
- Illegal op (11): data is forced to 0x00000000 and rsp_err = 1. It still occupies a slot and returns in order.
- Handshake and advance rules:
  - s2_free = !s2_valid OR rsp_ready.
  - s1_adv = s1_valid AND s2_free.
  - req_ready = !s1_valid OR s1_adv.
  - Accept on req_valid AND req_ready. Transfer out on rsp_valid AND rsp_ready.
- Latency: a request accepted at edge t shows rsp_valid = 1 after edge t+1, provided there is no stall. Throughput is 1 per cycle.
- Ordering: responses always come out in acceptance order. The unit never drops or duplicates an op.
- Stall: while rsp_valid = 1 and rsp_ready = 0, rsp_data, rsp_tag and rsp_err stay stable. S1 holds its op and req_ready follows the rules above, so at most 2 ops are in flight.
- Simultaneous events:
  - S2 output accepted and S1 advancing in the same cycle: S2 reloads from S1, with no bubble.
  - New request accepted in the same cycle that S1 advances: S1 reloads.
- Flush at edge t: s1_valid and s2_valid clear at that edge, and any request offered that cycle is not accepted (req_ready = 0 while flush = 1). rsp_valid = 0 from the next cycle.
- Boundary values: shamt = 0 passes the operand unchanged for all legal ops, and SRA with shamt = 0 applies no fill. shamt = 31 is the maximum; there is no wrap.
- busy reflects the registered valids only.

Test Plan:
- Individual ops with rsp_ready = 1:
  - SLL a=0x00000001, shamt=31 -> 0x80000000.
  - SRL a=0x80000000, shamt=4 -> 0x08000000.
  - SRA a=0x80000000, shamt=4 -> 0xF8000000.
  - SRA a=0x7FFFFFFF, shamt=31 -> 0x00000000.
  - All of the above show rsp_valid exactly 2 edges after acceptance, with rsp_err = 0.
- Boundary: SRA a=0x80000001, shamt=0 -> 0x80000001. Illegal op=11, a=0xFFFFFFFF, tag=5 -> rsp_data=0, rsp_err=1, rsp_tag=5.
- Back-to-back: 8 requests on consecutive cycles, tags 0..7, rsp_ready = 1 -> 8 consecutive responses in tag order, req_ready never low.
- Backpressure: hold rsp_ready = 0 while offering tags 1, 2, 3.
  - Tags 1 and 2 are accepted; req_ready goes 0.
  - rsp_data holds tag 1's value stable.
  - Release rsp_ready -> tags 1, 2, 3 return in order with no loss.
- Flush: assert flush with 2 ops in flight and one offered -> no responses for them, busy = 0 next cycle, and the next request completes normally.
- Async reset: drop rst_n mid-cycle with 2 ops in flight -> all outputs go 0 immediately, no stale response after release, and req_ready = 1.
